// File: rtl/vscale_xvec_vstore.sv
// Vector store sequencer: drains one captured vector into per-lane word writes
// over a valid/ready memory request channel, lane 0 first, with a byte stride.
module vscale_xvec_vstore #(
  parameter int XPR_LEN = 32,
  parameter int NLANES  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [NLANES*XPR_LEN-1:0]   vec_data,
  input  logic [XPR_LEN-1:0]          base_addr,
  input  logic [XPR_LEN-1:0]          stride,
  input  logic [5:0]                  vl,
  output logic                        dmem_req_valid,
  input  logic                        dmem_req_ready,
  output logic [XPR_LEN-1:0]          dmem_addr,
  output logic [XPR_LEN-1:0]          dmem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        misaligned
);

  localparam int VW = NLANES * XPR_LEN;
  localparam int CW = $clog2(NLANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t             state_reg;
  logic [VW-1:0]      lane_sr_reg;
  logic [VW-1:0]      lane_sr_shifted;
  logic [XPR_LEN-1:0] addr_reg;
  logic [XPR_LEN-1:0] stride_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      vl_eff;
  logic               err_reg;
  logic               misalign_in;

  // Lane i takes lane i+1; the top lane is zero-filled.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_shift
      if (gi == NLANES - 1) begin : g_top
        assign lane_sr_shifted[gi*XPR_LEN +: XPR_LEN] = '0;
      end else begin : g_mid
        assign lane_sr_shifted[gi*XPR_LEN +: XPR_LEN] = lane_sr_reg[(gi+1)*XPR_LEN +: XPR_LEN];
      end
    end
  endgenerate

  always_comb begin
    vl_eff = CW'(vl);
    if (32'(vl) > 32'(NLANES)) vl_eff = CW'(NLANES);
  end

  assign misalign_in = (base_addr[1:0] != 2'b00) || (stride[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      lane_sr_reg <= '0;
      addr_reg    <= '0;
      stride_reg  <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_valid) begin
            lane_sr_reg <= vec_data;
            addr_reg    <= base_addr;
            stride_reg  <= stride;
            cnt_reg     <= vl_eff;
            err_reg     <= misalign_in;
            if (misalign_in || (vl_eff == '0)) state_reg <= S_DONE;
            else                               state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (dmem_req_ready) begin
            lane_sr_reg <= lane_sr_shifted;
            addr_reg    <= addr_reg + stride_reg;
            cnt_reg     <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) state_reg <= S_DONE;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so ready never feeds valid/addr/data.
  assign start_ready    = (state_reg == S_IDLE);
  assign busy           = (state_reg != S_IDLE);
  assign dmem_req_valid = (state_reg == S_WRITE);
  assign done           = (state_reg == S_DONE);
  assign misaligned     = (state_reg == S_DONE) && err_reg;
  assign dmem_addr      = addr_reg;
  assign dmem_wdata     = lane_sr_reg[XPR_LEN-1:0];

endmodule

// File: tb/tb_vscale_xvec_vstore.sv
// Directed bench for vscale_xvec_vstore: table of store commands plus a
// hand-written mid-store reset sequence.
module tb_vscale_xvec_vstore;

  logic          clk;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [1023:0] vec_data;
  logic [31:0]   base_addr;
  logic [31:0]   stride;
  logic [5:0]    vl;
  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          busy;
  logic          done;
  logic          misaligned;

  int errors = 0;
  int checks = 0;

  vscale_xvec_vstore #(.XPR_LEN(32), .NLANES(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .vec_data       (vec_data),
    .base_addr      (base_addr),
    .stride         (stride),
    .vl             (vl),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .busy           (busy),
    .done           (done),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [5:0]  vl;
    int          stall_lane;
    int          stall_cyc;
    int          exp_writes;
    int          exp_done;
    logic        exp_mis;
    logic [31:0] exp_last_addr;
    logic [7:0]  seed;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] lane_val(input logic [7:0] seed, input int i);
    return {seed, 16'h0000, 8'(8'hA0 + i)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_vec(input logic [7:0] seed);
    for (int i = 0; i < 32; i++) vec_data[i*32 +: 32] = lane_val(seed, i);
  endtask

  task automatic run_cmd(input vec_t v, input int id);
    int          k;
    int          stall_left;
    int          done_c;
    logic [31:0] last_a;
    logic [31:0] ea;
    build_vec(v.seed);
    @(negedge clk);
    base_addr   = v.base;
    stride      = v.stride;
    vl          = v.vl;
    start_valid = 1'b1;
    chk($sformatf("v%0d start_ready", id), 32'(start_ready), 32'd1);
    @(posedge clk);
    #1 start_valid = 1'b0;
    k = 0;
    stall_left = v.stall_cyc;
    done_c = 0;
    last_a = 32'h0;
    for (int c = 1; c <= 100 && done_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk($sformatf("v%0d start_ready_drop", id), 32'(start_ready), 32'd0);
      if (dmem_req_valid) begin
        ea = v.base + 32'(k) * v.stride;
        chk($sformatf("v%0d lane%0d addr", id, k), dmem_addr, ea);
        chk($sformatf("v%0d lane%0d data", id, k), dmem_wdata, lane_val(v.seed, k));
        last_a = dmem_addr;
        if (k == v.stall_lane && stall_left > 0) begin
          dmem_req_ready = 1'b0;
          stall_left--;
        end else begin
          dmem_req_ready = 1'b1;
          k++;
        end
      end else begin
        dmem_req_ready = 1'b1;
      end
      if (done) begin
        done_c = c;
        chk($sformatf("v%0d misaligned", id), 32'(misaligned), 32'(v.exp_mis));
      end
    end
    if (done_c == 0) begin
      errors++;
      $display("FAIL v%0d timeout: got no done expected done", id);
    end
    chk($sformatf("v%0d done_cycle", id), 32'(done_c), 32'(v.exp_done));
    chk($sformatf("v%0d writes", id), 32'(k), 32'(v.exp_writes));
    if (v.exp_writes > 0) chk($sformatf("v%0d last_addr", id), last_a, v.exp_last_addr);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", id), 32'(done), 32'd0);
    chk($sformatf("v%0d idle_after", id), 32'(start_ready), 32'd1);
    $display("cmd %0d: base=%h stride=%h vl=%0d writes=%0d done_cycle=%0d misaligned=%0d",
             id, v.base, v.stride, v.vl, k, done_c, v.exp_mis);
  endtask

  initial begin
    vecs[0] = '{32'h1000, 32'h4, 6'd3, -1, 0, 3, 4, 1'b0, 32'h1008, 8'h00};
    vecs[1] = '{32'h1000, 32'h4, 6'd3, 1, 2, 3, 6, 1'b0, 32'h1008, 8'h01};
    vecs[2] = '{32'h2000, 32'hFFFFFFF8, 6'd40, -1, 0, 32, 33, 1'b0, 32'h1F08, 8'h02};
    vecs[3] = '{32'hFFFFFFFC, 32'h4, 6'd2, -1, 0, 2, 3, 1'b0, 32'h0000_0000, 8'h03};
    vecs[4] = '{32'h1002, 32'h4, 6'd4, -1, 0, 0, 1, 1'b1, 32'h0, 8'h04};
    vecs[5] = '{32'h3000, 32'h4, 6'd0, -1, 0, 0, 1, 1'b0, 32'h0, 8'h05};
    vecs[6] = '{32'h1000, 32'h6, 6'd2, -1, 0, 0, 1, 1'b1, 32'h0, 8'h06};
    vecs[7] = '{32'h40, 32'h100, 6'd1, -1, 0, 1, 2, 1'b0, 32'h40, 8'h07};

    reset = 1'b1;
    start_valid = 1'b0;
    vec_data = '0;
    base_addr = '0;
    stride = '0;
    vl = '0;
    dmem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset start_ready", 32'(start_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_valid", 32'(dmem_req_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset addr", dmem_addr, 32'h0);
    chk("reset wdata", dmem_wdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], i);

    // Reset while lane 2 of an 8-lane store is on the bus.
    build_vec(8'h0C);
    @(negedge clk);
    base_addr = 32'h5000;
    stride = 32'h4;
    vl = 6'd8;
    start_valid = 1'b1;
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst lane2 data", dmem_wdata, lane_val(8'h0C, 2));
    chk("rst lane2 addr", dmem_addr, 32'h5008);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst start_ready", 32'(start_ready), 32'd1);
    chk("rst req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst addr", dmem_addr, 32'h0);
    chk("rst wdata", dmem_wdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst no_done c%0d", c), 32'(done | busy), 32'd0);
    end
    $display("cmd reset: 8-lane store abandoned at lane 2");

    run_cmd('{32'h6000, 32'h4, 6'd2, -1, 0, 2, 3, 1'b0, 32'h6004, 8'h0D}, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_xvec_vstore.md
# vscale_xvec_vstore

Vector store sequencer for the xvec extension. Takes one full-width vector result (NLANES × XPR_LEN bits, lane 0 in the least-significant XPR_LEN bits) together with a base address, byte stride and active lane count. Emits one word-sized data-memory write per active lane over a valid/ready request channel. Sits between the xvec ALU/vector register write port and the data-memory arbiter; it is the drain side of the wide vector bus the ALU produces.

## Interface
Parameters:
- XPR_LEN, 32, lane width in bits; also the address width.
- NLANES, 32, lanes per vector.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  store command present.
- start_ready  output  1  block can accept a command; high only in IDLE.
- vec_data  input  NLANES*XPR_LEN  vector to store; lane i = bits [i*XPR_LEN +: XPR_LEN].
- base_addr  input  XPR_LEN  byte address of lane 0.
- stride  input  XPR_LEN  byte stride between lanes, two's complement.
- vl  input  6  active lane count; values above NLANES are clamped to NLANES.
- dmem_req_valid  output  1  write request valid.
- dmem_req_ready  input  1  memory accepts the request this cycle.
- dmem_addr  output  XPR_LEN  request byte address.
- dmem_wdata  output  XPR_LEN  request write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  qualifies done: command was rejected for misalignment.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, capture vec_data into a lane shift register, base_addr into an address register, stride, and vl_eff = min(vl, NLANES) into a remaining-lane counter.
  - Misalignment check at capture: if base_addr[1:0]≠0 or stride[1:0]≠0, latch err=1 and go to DONE. No requests are issued.
  - If vl_eff=0, latch err=0 and go to DONE.
  - Otherwise latch err=0 and go to WRITE.
- WRITE:
  - dmem_req_valid=1, dmem_addr = address register, dmem_wdata = shift register lane 0.
  - On dmem_req_valid && dmem_req_ready: shift right by XPR_LEN, address += stride, counter −1. If the counter was 1, go to DONE.
  - Without ready, all outputs hold stable; the request is never withdrawn.
- DONE: done=1 and misaligned=err for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^XPR_LEN; wrap-around is silent and not an error.
- Lanes are issued strictly in order 0..vl_eff−1. Lanes at or above vl_eff are never written.
- start_valid is ignored outside IDLE; the command source must hold it until start_ready.

## Timing
- Reset values: state IDLE, start_ready=1, busy=0, dmem_req_valid=0, done=0, misaligned=0. dmem_addr, dmem_wdata and internal registers are 0.
- Reset has priority over every other event. Reset mid-WRITE abandons remaining lanes with no done pulse; the next cycle is IDLE.
- Command accepted at edge T:
  - Requests start in cycle T+1.
  - With dmem_req_ready held high, lane k is accepted in cycle T+1+k.
  - done is asserted in cycle T+1+vl_eff.
  - Minimum command-to-command spacing is vl_eff+2 cycles.
- vl=0 or misaligned: done in cycle T+1; dmem_req_valid never rises.
- No combinational path from dmem_req_ready to dmem_req_valid, dmem_addr or dmem_wdata. All outputs are registered or decoded from state only.
- start_ready drops the cycle after acceptance; it does not rise in the same cycle as done.

## Test plan
- base=0x1000, stride=4, vl=3, lanes=0xA0,0xA1,0xA2, ready always 1 -> writes (0x1000,0xA0),(0x1004,0xA1),(0x1008,0xA2) in consecutive cycles; done in cycle T+4 with misaligned=0.
- Same command with ready low for 2 cycles on lane 1 -> lane 1 address/data held for 3 cycles, each lane issued exactly once; done in cycle T+6.
- base=0x2000, stride=0xFFFFFFF8 (−8), vl=40 -> exactly 32 writes at 0x2000, 0x1FF8, … 0x1F08; lane 31 data = vec_data[1023:992].
- base=0xFFFFFFFC, stride=4, vl=2 -> addresses 0xFFFFFFFC then 0x00000000, with no error.
- base=0x1002, vl=4 -> no request; done=1 and misaligned=1 in cycle T+1. Separately, vl=0 -> done=1, misaligned=0, no request.
- Reset asserted during lane 2 of an 8-lane store -> next cycle IDLE with all outputs at reset values and no done pulse. A new command then starts at lane 0 of its own data.
